// File: rtl/axi_lite_pkg.sv
// Shared types and address helper for the AXI4-Lite memory slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Word offset from the base; callers truncate to the index width they need.
  function automatic logic [63:0] addr2idx(input logic [63:0] i_addr,
                                           input logic [63:0] i_base,
                                           input int unsigned i_lsb);
    return (i_addr - i_base) >> i_lsb;
  endfunction

endpackage

// File: rtl/axi_lite_slv_mem.sv
// Word memory with one byte-enabled write port and one registered read port.
// The read register samples the array before a same-edge write lands.
module axi_lite_slv_mem
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [DATA_W/8-1:0]        i_wstrb,
  input  logic                       i_re,
  input  logic                       i_rclr,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // i_rclr returns zero for reads that decode outside the mapped window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave fronting a word-addressed memory, independent write/read channels.
// Define AXI_LITE_SLV_DECERR_EN to answer out-of-window accesses with SLVERR instead of aliasing.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int          IDX_W  = $clog2(DEPTH);

  wr_state_t          r_wstate;
  wr_state_t          w_wstate_nxt;
  rd_state_t          r_rstate;
  rd_state_t          w_rstate_nxt;
  logic               r_ready_en;
  logic               r_aw_held;
  logic               r_w_held;
  logic [ADDR_W-1:0]  r_awaddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  resp_t              r_bresp;
  resp_t              r_rresp;

  logic               w_awready;
  logic               w_wready;
  logic               w_bvalid;
  logic               w_arready;
  logic               w_rvalid;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_commit;
  logic               w_aw_ok;
  logic               w_ar_ok;
  resp_t              w_wr_resp;
  resp_t              w_rd_resp;
  logic [IDX_W-1:0]   w_aw_idx;
  logic [IDX_W-1:0]   w_ar_idx;
  logic [DATA_W-1:0]  w_rdata;

  // Index truncation to IDX_W is the modulo-DEPTH aliasing of the default build.
  assign w_aw_idx = IDX_W'(addr2idx(64'(r_awaddr), 64'(BASE_ADDR), LSB));
  assign w_ar_idx = IDX_W'(addr2idx(64'(S_AXI_ARADDR), 64'(BASE_ADDR), LSB));

`ifdef AXI_LITE_SLV_DECERR_EN
  assign w_aw_ok = (64'(r_awaddr) >= 64'(BASE_ADDR)) &&
                   (addr2idx(64'(r_awaddr), 64'(BASE_ADDR), LSB) < 64'(DEPTH));
  assign w_ar_ok = (64'(S_AXI_ARADDR) >= 64'(BASE_ADDR)) &&
                   (addr2idx(64'(S_AXI_ARADDR), 64'(BASE_ADDR), LSB) < 64'(DEPTH));
`else
  assign w_aw_ok = 1'b1;
  assign w_ar_ok = 1'b1;
`endif

  assign w_wr_resp = w_aw_ok ? OKAY : SLVERR;
  assign w_rd_resp = w_ar_ok ? OKAY : SLVERR;

  assign w_aw_hs  = S_AXI_AWVALID & w_awready;
  assign w_w_hs   = S_AXI_WVALID  & w_wready;
  assign w_ar_hs  = S_AXI_ARVALID & w_arready;
  assign w_commit = (r_wstate == W_IDLE) & r_aw_held & r_w_held;

  // Keeps all READY outputs low for the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (r_aw_held && r_w_held) w_wstate_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY)          w_wstate_nxt = W_IDLE;
      default:                            w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_awready = r_ready_en & ~r_aw_held & (r_wstate == W_IDLE);
    w_wready  = r_ready_en & ~r_w_held  & (r_wstate == W_IDLE);
    w_bvalid  = (r_wstate == W_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
      end else if (w_commit) begin
        r_aw_held <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
      end else if (w_commit) begin
        r_w_held <= 1'b0;
      end
      if (w_commit) begin
        r_bresp <= w_wr_resp;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_aw_hs) begin
      r_awaddr <= S_AXI_AWADDR;
    end
    if (w_w_hs) begin
      r_wdata <= S_AXI_WDATA;
      r_wstrb <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (S_AXI_ARVALID && r_ready_en) w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY)                w_rstate_nxt = R_IDLE;
      default:                                  w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready = r_ready_en & (r_rstate == R_IDLE);
    w_rvalid  = (r_rstate == R_DATA);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rresp <= OKAY;
    end else if (w_ar_hs) begin
      r_rresp <= w_rd_resp;
    end
  end

  axi_lite_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk   (ACLK),
    .i_rst_n (ARESETn),
    .i_we    (w_commit & w_aw_ok),
    .i_waddr (w_aw_idx),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .i_re    (w_ar_hs),
    .i_rclr  (~w_ar_ok),
    .i_raddr (w_ar_idx),
    .o_rdata (w_rdata)
  );

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = w_rdata;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: directed vector table, corner sequences, randomized traffic.
module tb_axi_lite_mem_slave;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [1:0]  OK     = 2'b00;
  localparam logic [1:0]  SLV    = 2'b10;

  logic              ACLK;
  logic              ARESETn;
  logic [31:0]       S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [31:0]       S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  axi_lite_mem_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain byte-addressed memory behind the address window rules.
  logic [31:0] mdl_mem [DEPTH];

  function automatic bit mdl_hit(input logic [31:0] addr);
`ifdef AXI_LITE_SLV_DECERR_EN
    logic [31:0] off;
    off = addr - BASE;
    return (addr >= BASE) && (off < 32'(DEPTH * 4));
`else
    return (addr == addr);
`endif
  endfunction

  function automatic int mdl_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int w;
    if (mdl_hit(addr)) begin
      w = mdl_word(addr);
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl_mem[w][8*b +: 8] = data[8*b +: 8];
      resp = OK;
    end else begin
      resp = SLV;
    end
  endtask

  task automatic mdl_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    if (mdl_hit(addr)) begin
      data = mdl_mem[mdl_word(addr)];
      resp = OK;
    end else begin
      data = 32'h0;
      resp = SLV;
    end
  endtask

  // Every driver task starts and ends 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd,
                          output logic [1:0] resp, output bit lat_ok, output int hold_bad,
                          output bit rdy_after, output bit tmo);
    bit aw_done = 0, w_done = 0, b_seen = 0, b_done = 0;
    int aw_e = -1, w_e = -1, b_first = -1, cyc = 0, hs_e;
    logic [1:0] resp0 = 2'b00;
    hold_bad = 0; resp = 2'b00; lat_ok = 0; rdy_after = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!b_done && cyc < 200) begin
      S_AXI_AWVALID = !aw_done && (cyc >= awd);
      S_AXI_WVALID  = !w_done && (cyc >= wd);
      S_AXI_BREADY  = b_seen && (cyc - b_first >= bd);
      @(negedge ACLK);
      if (S_AXI_BVALID && !b_seen) begin
        b_seen = 1; b_first = cyc; resp0 = S_AXI_BRESP;
      end
      if (b_seen && (!S_AXI_BVALID || S_AXI_BRESP !== resp0 || S_AXI_AWREADY || S_AXI_WREADY))
        hold_bad++;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1; aw_e = cyc; end
      if (S_AXI_WVALID && S_AXI_WREADY)   begin w_done = 1;  w_e = cyc;  end
      if (S_AXI_BVALID && S_AXI_BREADY)   begin b_done = 1;  resp = S_AXI_BRESP; end
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    tmo = !b_done;
    hs_e = (aw_e > w_e) ? aw_e : w_e;
    lat_ok = b_seen && (b_first == hs_e + 2);
    @(negedge ACLK);
    rdy_after = S_AXI_AWREADY && S_AXI_WREADY;
    @(posedge ACLK); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ard, input int rd,
                         output logic [31:0] data, output logic [1:0] resp, output bit lat_ok,
                         output int hold_bad, output bit rdy_after, output bit tmo);
    bit ar_done = 0, r_seen = 0, r_done = 0;
    int ar_e = -1, r_first = -1, cyc = 0;
    hold_bad = 0; data = 32'h0; resp = 2'b00; lat_ok = 0; rdy_after = 0;
    S_AXI_ARADDR = addr;
    while (!r_done && cyc < 200) begin
      S_AXI_ARVALID = !ar_done && (cyc >= ard);
      S_AXI_RREADY  = r_seen && (cyc - r_first >= rd);
      @(negedge ACLK);
      if (S_AXI_RVALID && !r_seen) begin
        r_seen = 1; r_first = cyc; data = S_AXI_RDATA; resp = S_AXI_RRESP;
      end
      if (r_seen && (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp || S_AXI_ARREADY))
        hold_bad++;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin ar_done = 1; ar_e = cyc; end
      if (S_AXI_RVALID && S_AXI_RREADY)   r_done = 1;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    tmo = !r_done;
    lat_ok = r_seen && (r_first == ar_e + 1);
    @(negedge ACLK);
    rdy_after = S_AXI_ARREADY;
    @(posedge ACLK); #1;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int awd, input int wd, input int bd,
                        input logic [1:0] exp_resp);
    logic [1:0] resp; bit lat_ok, rdy_after, tmo; int hold_bad;
    do_write(addr, data, strb, awd, wd, bd, resp, lat_ok, hold_bad, rdy_after, tmo);
    check({tag, ".b_timeout"}, tmo, 0);
    check({tag, ".bresp"}, resp, exp_resp);
    check({tag, ".b_latency"}, lat_ok, 1);
    check({tag, ".b_hold"}, hold_bad, 0);
    check({tag, ".wr_ready_after"}, rdy_after, 1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input int ard, input int rd,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] data; logic [1:0] resp; bit lat_ok, rdy_after, tmo; int hold_bad;
    do_read(addr, ard, rd, data, resp, lat_ok, hold_bad, rdy_after, tmo);
    check({tag, ".r_timeout"}, tmo, 0);
    check({tag, ".rdata"}, data, exp_data);
    check({tag, ".rresp"}, resp, exp_resp);
    check({tag, ".r_latency"}, lat_ok, 1);
    check({tag, ".r_hold"}, hold_bad, 0);
    check({tag, ".ar_ready_after"}, rdy_after, 1);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd;
    int          wd;
    int          bd;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    int          ard;
    int          rd;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0]  r;
    logic [31:0] d, a, old;
    int dup;

    vecs.push_back('{32'h1000, 32'hDEADBEEF, 4'hF, 2, 5, 0,  OK, 32'h1000, 0, 0,  32'hDEADBEEF, OK});
    vecs.push_back('{32'h1000, 32'h0000CAFE, 4'h3, 0, 0, 0,  OK, 32'h1000, 0, 0,  32'hDEADCAFE, OK});
    vecs.push_back('{32'h1008, 32'hA5A5A5A5, 4'hF, 1, 0, 20, OK, 32'h1008, 1, 20, 32'hA5A5A5A5, OK});
    vecs.push_back('{32'h1013, 32'h11223344, 4'hF, 0, 2, 1,  OK, 32'h1010, 0, 1,  32'h11223344, OK});
    vecs.push_back('{32'h1010, 32'h00AB0000, 4'h4, 3, 0, 0,  OK, 32'h1012, 2, 0,  32'h11AB3344, OK});
`ifdef AXI_LITE_SLV_DECERR_EN
    vecs.push_back('{32'h2000, 32'h99887766, 4'hF, 0, 0, 0,  SLV, 32'h1000, 0, 0, 32'hDEADCAFE, OK});
    vecs.push_back('{32'h2004, 32'h55443322, 4'hF, 0, 1, 0,  SLV, 32'h2004, 0, 0, 32'h00000000, SLV});
    vecs.push_back('{32'h0FFC, 32'h01020304, 4'hF, 1, 0, 0,  SLV, 32'h0FFC, 0, 0, 32'h00000000, SLV});
`else
    vecs.push_back('{32'h2000, 32'h99887766, 4'hF, 0, 0, 0,  OK, 32'h1000, 0, 0,  32'h99887766, OK});
    vecs.push_back('{32'h2004, 32'h55443322, 4'hF, 0, 1, 0,  OK, 32'h2004, 0, 0,  32'h55443322, OK});
    vecs.push_back('{32'h0FFC, 32'h01020304, 4'hF, 1, 0, 0,  OK, 32'h0FFC, 0, 0,  32'h01020304, OK});
`endif

    ARESETn = 0;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst.ready_valid", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 0);
    check("rst.resps", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst.rdata", S_AXI_RDATA, 0);
    ARESETn = 1;
    #1;
    check("rel.ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(posedge ACLK); @(posedge ACLK); #1;
    check("rel.ready_after_2_edges", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    foreach (vecs[i]) begin
      mdl_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, r);
      wr_chk($sformatf("vec%0d", i), vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].awd, vecs[i].wd, vecs[i].bd, vecs[i].exp_bresp);
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].ard, vecs[i].rd,
             vecs[i].exp_rdata, vecs[i].exp_rresp);
    end

    // Read and write of word 4 resolving on the same edge.
    mdl_read(32'h1010, old, r);
    S_AXI_AWADDR = 32'h1010; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 32'h1010; S_AXI_ARVALID = 1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    @(negedge ACLK);
    check("hazard.bvalid", S_AXI_BVALID, 1);
    check("hazard.rvalid", S_AXI_RVALID, 1);
    check("hazard.old_rdata", S_AXI_RDATA, old);
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    mdl_write(32'h1010, 32'h12345678, 4'hF, r);
    rd_chk("hazard.after", 32'h1010, 0, 0, 32'h12345678, OK);

    // Reset pulsed while a write response is pending.
    S_AXI_AWADDR = 32'h1020; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("midrst.bvalid_before", S_AXI_BVALID, 1);
    #2 ARESETn = 0;
    #1;
    check("midrst.bvalid_dropped", S_AXI_BVALID, 0);
    check("midrst.ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    mdl_write(32'h1020, 32'h0BADF00D, 4'hF, r);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1;
    S_AXI_BREADY = 1;
    dup = 0;
    repeat (10) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) dup++;
    end
    check("midrst.no_dup_b", dup, 0);
    S_AXI_BREADY = 0;
    @(posedge ACLK); #1;
    rd_chk("midrst.mem_kept", 32'h1020, 0, 0, 32'h0BADF00D, OK);

    for (int i = 0; i < 32; i++) begin
      a = BASE + 32'h80 + 32'(4 * i);
      d = $urandom;
      mdl_write(a, d, 4'hF, r);
      wr_chk($sformatf("init%0d", i), a, d, 4'hF, 0, 0, 0, r);
    end

    for (int i = 0; i < 80; i++) begin
      logic [3:0] strb;
      a = BASE + 32'(4 * $urandom_range(32, 63)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = a + 32'h1000;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        strb = 4'($urandom_range(1, 15));
        mdl_write(a, d, strb, r);
        wr_chk($sformatf("rnd%0d_wr@%h", i, a), a, d, strb,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
      end else begin
        mdl_read(a, d, r);
        rd_chk($sformatf("rnd%0d_rd@%h", i, a), a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
